// File: rtl/lcd_cmd_scheduler_if.sv
// Host-side and engine-side handshakes of the LCD command scheduler.
// master drives host commands and engine status; slave is the scheduler.
interface lcd_cmd_scheduler_if;
   logic [3:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic [3:0] lcd_cmd;
   logic       lcd_cmd_valid;
   logic       lcd_busy;
   logic       lcd_done;

   modport master (
      output host_cmd, host_valid, lcd_busy, lcd_done,
      input  host_ready, lcd_cmd, lcd_cmd_valid
   );

   modport slave (
      input  host_cmd, host_valid, lcd_busy, lcd_done,
      output host_ready, lcd_cmd, lcd_cmd_valid
   );
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// Queues host opcodes and issues them one at a time to the LCD engine.
// Illegal opcodes are counted and dropped; a completed Write ends the run.
module lcd_cmd_scheduler #(
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3,
   parameter int ACK_TO = 4
) (
   input  logic               clk,
   input  logic               reset,
   lcd_cmd_scheduler_if.slave bus,
   output logic [PTR_W:0]     fifo_level,
   output logic               seq_done,
   output logic [7:0]         err_cnt
);

   localparam int TW = $clog2(ACK_TO + 1);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_IDLE,
      S_CHECK,
      S_WAIT_DONE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic [3:0]       cmd_q;
   logic             valid_q;
   logic             accept, push, bad, pop;

   // Host may hand over a command unless full or the sequence has ended.
   assign bus.host_ready = !reset && (count != FULL) && (state_q != S_DONE);
   assign accept = bus.host_valid && bus.host_ready;
   assign push   = accept && (bus.host_cmd < 4'd12);
   assign bad    = accept && (bus.host_cmd >= 4'd12);

   assign bus.lcd_cmd       = cmd_q;
   assign bus.lcd_cmd_valid = valid_q;
   assign fifo_level        = count;
   assign seq_done          = (state_q == S_DONE);

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.host_cmd;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Saturating count of dropped illegal opcodes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      err_cnt <= '0;
      else if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end

   // Sequencer state, ack timer and the registered issue outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         cmd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         valid_q <= pop;
         if (pop) cmd_q <= mem[rd_ptr];
      end
   end

   // Next-state logic: issue only to an idle engine, then track completion.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!bus.lcd_busy && count != '0) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d   = TW'(ACK_TO);
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (bus.lcd_busy) begin
               state_d = S_WAIT_IDLE;
            end else begin
               tmo_d = tmo_q - 1'b1;
               if (tmo_q == TW'(1)) state_d = S_CHECK;
            end
         end
         S_WAIT_IDLE: begin
            if (!bus.lcd_busy) state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = (cmd_q == 4'd0) ? S_WAIT_DONE : S_IDLE;
         end
         S_WAIT_DONE: begin
            if (bus.lcd_done) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
